// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR sequencing controller.
//   fir_state_e : controller states (IDLE, MAC, DONE, CFG)
//   ptr_inc     : modulo-n increment of a ring pointer
//   ptr_sub     : modulo-n difference a - b of two ring positions (a, b < n)
// Pointers are passed as 8-bit values so one helper serves every N_TAPS;
// callers narrow the result back to their own address width.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2,
        CFG  = 2'd3
    } fir_state_e;

    function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input logic [7:0] n);
        logic [7:0] res;
        if (ptr >= (n - 8'd1)) begin
            res = 8'd0;
        end else begin
            res = ptr + 8'd1;
        end
        return res;
    endfunction

    function automatic logic [7:0] ptr_sub(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] n);
        logic [7:0] res;
        if (a >= b) begin
            res = a - b;
        end else begin
            res = (a + n) - b;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_ring_ptr.sv
// fir_ring_ptr: sample-ring write pointer counting modulo N_TAPS.
//   clk, reset_n : clock, asynchronous active-low reset (pointer -> 0)
//   inc          : advance the pointer by one position this cycle
//   ptr          : current write position, 0..N_TAPS-1
module fir_ring_ptr
    import fir_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int AW     = $clog2(N_TAPS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_r;

    // Pointer register: wraps from N_TAPS-1 back to 0 on increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= {AW{1'b0}};
        end else if (inc) begin
            ptr_r <= AW'(ptr_inc(8'(ptr_r), 8'(N_TAPS)));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequencer for a single-MAC FIR filter.
// Accepts one sample, writes it into the sample ring, then walks N_TAPS
// multiply-accumulate cycles pairing coefficient k with sample (base-k),
// presents the result until downstream takes it, and arbitrates the
// coefficient memory with a configuration master between samples.
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream sample handshake
//   out_valid / out_ready: downstream result handshake
//   x_wr_en, x_wr_addr   : sample ring write port
//   x_rd_addr            : sample ring read address for the current tap
//   c_addr               : coefficient address (tap index, or cfg_addr in CFG)
//   mac_clr, mac_en      : accumulator load / update controls
//   cfg_req, cfg_addr    : configuration master request and address
//   cfg_gnt              : configuration master owns coefficient memory
//   busy                 : controller is not idle
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int AW     = $clog2(N_TAPS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          x_wr_en,
    output logic [AW-1:0] x_wr_addr,
    output logic [AW-1:0] x_rd_addr,
    output logic [AW-1:0] c_addr,
    output logic          mac_clr,
    output logic          mac_en,
    input  logic          cfg_req,
    input  logic [AW-1:0] cfg_addr,
    output logic          cfg_gnt,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);

    fir_state_e    state_r;
    fir_state_e    state_nxt_s;
    logic [AW-1:0] tap_r;
    logic [AW-1:0] tap_nxt_s;
    logic [AW-1:0] base_r;
    logic [AW-1:0] base_nxt_s;
    logic          accept_s;
    logic [AW-1:0] wr_ptr_s;

    fir_ring_ptr #(
        .N_TAPS(N_TAPS),
        .AW    (AW)
    ) u_wr_ptr (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (accept_s),
        .ptr    (wr_ptr_s)
    );

    // State, tap counter and sample base registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            tap_r   <= {AW{1'b0}};
            base_r  <= {AW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            tap_r   <= tap_nxt_s;
            base_r  <= base_nxt_s;
        end
    end

    // Next-state logic; configuration has priority over a new sample in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        tap_nxt_s   = tap_r;
        base_nxt_s  = base_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_req) begin
                    state_nxt_s = CFG;
                end else if (in_valid) begin
                    accept_s    = 1'b1;
                    base_nxt_s  = wr_ptr_s;
                    tap_nxt_s   = {AW{1'b0}};
                    state_nxt_s = MAC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MAC: begin
                if (tap_r == LAST_TAP) begin
                    tap_nxt_s   = {AW{1'b0}};
                    state_nxt_s = DONE;
                end else begin
                    tap_nxt_s   = tap_r + AW'(1'b1);
                    state_nxt_s = MAC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            CFG: begin
                if (!cfg_req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CFG;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                tap_nxt_s   = {AW{1'b0}};
                base_nxt_s  = {AW{1'b0}};
            end
        endcase
    end

    // Output decode. The IDLE handshake outputs are gated by reset_n so
    // nothing is offered or written while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        x_wr_en   = 1'b0;
        x_wr_addr = wr_ptr_s;
        x_rd_addr = {AW{1'b0}};
        c_addr    = {AW{1'b0}};
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        cfg_gnt   = 1'b0;
        busy      = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = reset_n & ~cfg_req;
                x_wr_en  = reset_n & accept_s;
            end
            MAC: begin
                busy      = 1'b1;
                mac_en    = 1'b1;
                mac_clr   = (tap_r == {AW{1'b0}});
                c_addr    = tap_r;
                // Newest sample first: tap k reads the sample k positions older.
                x_rd_addr = AW'(ptr_sub(8'(base_r), 8'(tap_r), 8'(N_TAPS)));
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            CFG: begin
                busy    = 1'b1;
                cfg_gnt = 1'b1;
                c_addr  = cfg_addr;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: a directed cycle table, hand-written
// corner sequences, and randomized traffic checked against a transaction-level
// reference model. A second N_TAPS=3 instance covers the non-power-of-two ring.
module tb_fir_seq_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0, cfg_req = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic       in_ready, out_valid, x_wr_en, mac_clr, mac_en, cfg_gnt, busy;
    logic [1:0] x_wr_addr, x_rd_addr, c_addr;

    logic       iv3 = 1'b0, or3 = 1'b0, cr3 = 1'b0;
    logic [1:0] ca3 = 2'd0;
    logic       ir3, ov3, we3, clr3, en3, gnt3, bsy3;
    logic [1:0] wa3, ra3, cad3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fir_seq_ctrl #(.N_TAPS(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .x_wr_en(x_wr_en),
        .x_wr_addr(x_wr_addr), .x_rd_addr(x_rd_addr), .c_addr(c_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .cfg_req(cfg_req), .cfg_addr(cfg_addr),
        .cfg_gnt(cfg_gnt), .busy(busy)
    );

    fir_seq_ctrl #(.N_TAPS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv3), .in_ready(ir3),
        .out_valid(ov3), .out_ready(or3), .x_wr_en(we3),
        .x_wr_addr(wa3), .x_rd_addr(ra3), .c_addr(cad3),
        .mac_clr(clr3), .mac_en(en3), .cfg_req(cr3), .cfg_addr(ca3),
        .cfg_gnt(gnt3), .busy(bsy3)
    );

    // Observation vector layout: {ir,ov,we,wa[1:0],ra[1:0],ca[1:0],clr,en,gnt,bsy}
    logic [12:0] obs, obs3;
    assign obs  = {in_ready, out_valid, x_wr_en, x_wr_addr, x_rd_addr, c_addr,
                   mac_clr, mac_en, cfg_gnt, busy};
    assign obs3 = {ir3, ov3, we3, wa3, ra3, cad3, clr3, en3, gnt3, bsy3};

    // Directed table records
    typedef struct {
        logic        iv;
        logic        ordy;
        logic        cr;
        logic [1:0]  ca;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[$];

    // Reference model state (transaction view)
    int m_cyc, m_acc, m_base, m_wr_cnt;
    bit m_cfg;
    logic [12:0] last_obs;
    int cyc;

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int iv, input int ordy, input int cr, input int ca,
                       input int ir, input int ov, input int we, input int wa,
                       input int ra, input int cad, input int clr, input int en,
                       input int gnt, input int bsy);
        vec_t v;
        v.iv   = 1'(iv);
        v.ordy = 1'(ordy);
        v.cr   = 1'(cr);
        v.ca   = 2'(ca);
        v.exp  = {1'(ir), 1'(ov), 1'(we), 2'(wa), 2'(ra), 2'(cad), 1'(clr), 1'(en),
                  1'(gnt), 1'(bsy)};
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        m_cyc = 0; m_acc = -1; m_base = 0; m_wr_cnt = 0; m_cfg = 0;
    endtask

    task automatic model_expect(output logic [12:0] e);
        logic ir, ov, we, clr, en, gnt, bsy;
        logic [1:0] wa, ra, ca;
        int d, k;
        ir = 0; ov = 0; we = 0; clr = 0; en = 0; gnt = 0; bsy = 0;
        ra = 0; ca = 0;
        wa = 2'(m_wr_cnt % N);
        if (m_cfg) begin
            gnt = 1; ca = cfg_addr; bsy = 1;
        end else if (m_acc >= 0) begin
            d = m_cyc - m_acc;
            bsy = 1;
            if (d <= N) begin
                k = d - 1;
                en = 1; clr = (k == 0); ca = 2'(k);
                ra = 2'((m_base - k + N) % N);
            end else begin
                ov = 1;
            end
        end else begin
            ir = !cfg_req;
            we = !cfg_req && in_valid;
        end
        e = {ir, ov, we, wa, ra, ca, clr, en, gnt, bsy};
    endtask

    task automatic model_update();
        if (m_cfg) begin
            if (!cfg_req) m_cfg = 0;
        end else if (m_acc >= 0) begin
            if ((m_cyc - m_acc) > N && out_ready) m_acc = -1;
        end else if (cfg_req) begin
            m_cfg = 1;
        end else if (in_valid) begin
            m_acc = m_cyc; m_base = m_wr_cnt % N; m_wr_cnt++;
        end
        m_cyc++;
    endtask

    // One cycle with model check: sample at negedge, advance past posedge.
    task automatic tick(input string name);
        logic [12:0] e;
        @(negedge clk);
        model_expect(e);
        last_obs = obs;
        chk(name, obs, e);
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        in_valid = 1; cfg_req = 0; out_ready = 0; cfg_addr = 0;
        iv3 = 1; cr3 = 0; or3 = 0; ca3 = 0;
        @(negedge clk);
        reset_n = 0;
        #1;
        chk("reset_outputs", obs, 13'h0);
        chk("reset_outputs_n3", obs3, 13'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        in_valid = 0; iv3 = 0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        int acc_cyc[$];
        int acc_addr[$];
        int q_wa[$];
        int q_ra[$];
        cyc = 0;
        model_reset();

        // Directed table: single sample, stalled DONE, then cfg vs sample race
        add(1,1,0,0, 1,0,1,0,0,0,0,0,0,0);
        add(0,1,0,0, 0,0,0,1,0,0,1,1,0,1);
        add(0,1,0,0, 0,0,0,1,3,1,0,1,0,1);
        add(0,1,0,0, 0,0,0,1,2,2,0,1,0,1);
        add(0,1,0,0, 0,0,0,1,1,3,0,1,0,1);
        add(0,0,0,0, 0,1,0,1,0,0,0,0,0,1);
        add(0,1,0,0, 0,1,0,1,0,0,0,0,0,1);
        add(1,0,1,2, 0,0,0,1,0,0,0,0,0,0);
        add(1,0,1,2, 0,0,0,1,0,2,0,0,1,1);
        add(1,0,0,2, 0,0,0,1,0,2,0,0,1,1);
        add(1,0,0,2, 1,0,1,1,0,0,0,0,0,0);
        add(0,0,0,0, 0,0,0,2,1,0,1,1,0,1);

        do_reset();
        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            cfg_req = tbl[i].cr; cfg_addr = tbl[i].ca;
            @(negedge clk);
            chk($sformatf("table[%0d]", i), obs, tbl[i].exp);
            @(posedge clk);
            #1;
            cyc++;
        end

        // Back-to-back samples: ring wrap and N_TAPS+2 accept spacing
        do_reset();
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 30; i++) begin
            tick("b2b");
            if (last_obs[10]) begin
                acc_cyc.push_back(i);
                acc_addr.push_back(int'(last_obs[9:8]));
            end
        end
        chk_int("b2b_count", acc_cyc.size(), 5);
        if (acc_cyc.size() == 5) begin
            for (int i = 0; i < 5; i++) chk_int("b2b_wr_addr", acc_addr[i], (i % N));
            for (int i = 1; i < 5; i++) chk_int("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], N + 2);
        end

        // Stalled result: out_valid holds for 10 cycles, in_ready returns after ack
        do_reset();
        in_valid = 1; out_ready = 0;
        tick("stall_accept");
        in_valid = 0;
        for (int i = 0; i < N; i++) tick("stall_mac");
        for (int i = 0; i < 10; i++) begin
            tick("stall_done");
            chk_int("stall_out_valid", int'(last_obs[11]), 1);
        end
        out_ready = 1;
        tick("stall_ack");
        tick("stall_idle");
        chk_int("stall_in_ready_after", int'(last_obs[12]), 1);

        // cfg_req raised mid-MAC waits until the controller is idle again
        do_reset();
        in_valid = 1; out_ready = 1;
        tick("cfgmac_accept");
        in_valid = 0;
        tick("cfgmac_tap0");
        cfg_req = 1; cfg_addr = 2'd3;
        for (int i = 0; i < N; i++) begin
            tick("cfgmac_hold");
            chk_int("cfgmac_no_gnt", int'(last_obs[1]), 0);
        end
        tick("cfgmac_idle");
        tick("cfgmac_grant");
        chk_int("cfgmac_gnt", int'(last_obs[1]), 1);
        cfg_req = 0;
        tick("cfgmac_release");
        tick("cfgmac_back");

        // Reset pulse at MAC tap 2 abandons the sample
        do_reset();
        in_valid = 1; out_ready = 1;
        tick("rstmac_accept");
        in_valid = 0;
        tick("rstmac_tap0");
        tick("rstmac_tap1");
        #2;
        chk_int("rstmac_at_tap2", int'(c_addr), 2);
        reset_n = 0;
        #1;
        chk("rstmac_async", obs, 13'h0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick("rstmac_quiet");
            chk_int("rstmac_no_out_valid", int'(last_obs[11]), 0);
        end
        in_valid = 1;
        tick("rstmac_next");
        chk_int("rstmac_wr_addr", int'(last_obs[9:8]), 0);
        chk_int("rstmac_wr_en", int'(last_obs[10]), 1);
        in_valid = 0;

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) cfg_req = !cfg_req;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            tick("random");
        end
        cfg_req = 0; in_valid = 0;

        // N_TAPS=3 ring: write sequence and read addressing for base 0
        do_reset();
        iv3 = 1; or3 = 1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (we3) q_wa.push_back(int'(wa3));
            if (en3 && q_ra.size() < 3) q_ra.push_back(int'(ra3));
            @(posedge clk);
            #1;
            cyc++;
        end
        iv3 = 0;
        chk_int("n3_accepts", (q_wa.size() >= 4) ? 1 : 0, 1);
        chk_int("n3_reads", q_ra.size(), 3);
        if (q_wa.size() >= 4) begin
            chk_int("n3_wa0", q_wa[0], 0);
            chk_int("n3_wa1", q_wa[1], 1);
            chk_int("n3_wa2", q_wa[2], 2);
            chk_int("n3_wa3", q_wa[3], 0);
        end
        if (q_ra.size() == 3) begin
            chk_int("n3_ra0", q_ra[0], 0);
            chk_int("n3_ra1", q_ra[1], 2);
            chk_int("n3_ra2", q_ra[2], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
